// File: rtl/demux1a8_buffered.sv
// Routes one N-bit producer stream into eight one-entry lane buffers, each
// with its own valid/ready handshake; broadcast writes every lane at once.
module demux1a8_buffered #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   data_in,
   input  logic [2:0]     control,
   input  logic           bcast,
   output logic [7:0]     out_valid,
   input  logic [7:0]     out_ready,
   output logic [8*N-1:0] out_data,
   output logic [3:0]     occupancy
);

   logic [7:0]   valid_reg;
   logic [7:0]   valid_next;
   logic [7:0]   lane_free;
   logic [7:0]   wr_en;
   logic [N-1:0] data_reg [8];
   logic [3:0]   occ_reg;
   logic [3:0]   occ_next;
   logic         accept;

   // A lane can take a word if it is empty or is being emptied this cycle.
   assign lane_free = ~valid_reg | out_ready;
   assign in_ready  = !reset && (bcast ? (&lane_free) : lane_free[control]);
   assign accept    = in_valid && in_ready;
   assign wr_en     = !accept ? 8'h00 : (bcast ? 8'hFF : (8'h01 << control));

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         // Write wins over drain so a same-cycle drain and refill keeps the lane valid.
         assign valid_next[gi] = wr_en[gi] ? 1'b1
                               : (out_ready[gi] ? 1'b0 : valid_reg[gi]);

         always_ff @(posedge clk) begin
            if (reset) begin
               data_reg[gi] <= '0;
            end else if (wr_en[gi]) begin
               data_reg[gi] <= data_in;
            end
         end

         assign out_data[gi*N +: N] = data_reg[gi];
      end
   endgenerate

   always_comb begin
      occ_next = 4'd0;
      for (int i = 0; i < 8; i++) begin
         occ_next = occ_next + {3'd0, valid_next[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg <= 8'h00;
         occ_reg   <= 4'd0;
      end else begin
         valid_reg <= valid_next;
         occ_reg   <= occ_next;
      end
   end

   assign out_valid = valid_reg;
   assign occupancy = occ_reg;

endmodule

// File: tb/tb_demux1a8_buffered.sv
// Scoreboard bench for demux1a8_buffered: per-lane word queues model the
// one-entry buffers; a negedge monitor pops and compares on every drain.
module tb_demux1a8_buffered;

   localparam int N = 32;

   logic           clk;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   data_in;
   logic [2:0]     control;
   logic           bcast;
   logic [7:0]     out_valid;
   logic [7:0]     out_ready;
   logic [8*N-1:0] out_data;
   logic [3:0]     occupancy;

   demux1a8_buffered #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .control   (control),
      .bcast     (bcast),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef logic [N-1:0] word_q_t [$];
   word_q_t      lane_q [8];
   logic [N-1:0] lane_word [8];
   int           checks = 0;
   int           passes = 0;
   bit           started = 0;

   function automatic void check(input string name, input logic [N-1:0] act,
                                 input logic [N-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endfunction

   // Monitor: compare the visible state to the model, then consume drains.
   always @(negedge clk) begin
      if (started) begin
         int cnt;
         cnt = 0;
         for (int i = 0; i < 8; i++) begin
            check($sformatf("out_valid[%0d]", i), {31'd0, out_valid[i]},
                  {31'd0, (lane_q[i].size() > 0)});
            check($sformatf("lane%0d_data", i), out_data[i*N +: N], lane_word[i]);
            if (lane_q[i].size() > 0) cnt++;
         end
         check("occupancy", {28'd0, occupancy}, cnt[N-1:0]);
         if (!reset) begin
            for (int i = 0; i < 8; i++) begin
               if (lane_q[i].size() > 0 && out_ready[i]) begin
                  logic [N-1:0] w;
                  w = lane_q[i].pop_front();
                  check($sformatf("drain%0d", i), out_data[i*N +: N], w);
               end
            end
         end
      end
   end

   // One clock of stimulus, entered and left 1 time unit after a rising edge.
   task automatic cycle(input logic rst, input logic iv, input logic bc,
                        input logic [2:0] ctl, input logic [N-1:0] d,
                        input logic [7:0] ordy);
      logic exp_rdy;
      logic all_free;
      reset     = rst;
      in_valid  = iv;
      bcast     = bc;
      control   = ctl;
      data_in   = d;
      out_ready = ordy;
      #8;
      // Drains were already popped by the monitor, so an empty queue means free.
      all_free = 1'b1;
      for (int i = 0; i < 8; i++) if (lane_q[i].size() != 0) all_free = 1'b0;
      exp_rdy = !rst && (bc ? all_free : (lane_q[ctl].size() == 0));
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            lane_q[i].delete();
            lane_word[i] = '0;
         end
      end else if (iv && exp_rdy) begin
         for (int i = 0; i < 8; i++) begin
            if (bc || i == int'(ctl)) begin
               lane_q[i].push_back(d);
               lane_word[i] = d;
            end
         end
         $display("accept t=%0t bcast=%0d lane=%0d data=%h", $time, bc, ctl, d);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; bcast = 1'b0; control = 3'd0;
      data_in = '0; out_ready = 8'h00;
      for (int i = 0; i < 8; i++) lane_word[i] = '0;
      @(posedge clk);
      #1;
      started = 1;
      cycle(1, 0, 0, 0, 0, 8'h00);

      // Single write, backpressure, second lane, drain-and-refill.
      cycle(0, 1, 0, 3, 32'hDEADBEEF, 8'h00);
      check("valid_after_first", {24'd0, out_valid}, 32'h08);
      cycle(0, 1, 0, 3, 32'h00000001, 8'h00);
      cycle(0, 1, 0, 5, 32'h00000055, 8'h00);
      check("valid_two_lanes", {24'd0, out_valid}, 32'h28);
      cycle(0, 1, 0, 3, 32'hCAFE0001, 8'h08);
      check("lane3_refill", out_data[3*N +: N], 32'hCAFE0001);

      // Broadcast blocked by lane 5, then accepted once lane 5 drains.
      cycle(0, 0, 0, 0, 0, 8'h08);
      cycle(0, 1, 1, 0, 32'hA5A5A5A5, 8'h00);
      cycle(0, 1, 1, 0, 32'hA5A5A5A5, 8'h20);
      check("bcast_valid", {24'd0, out_valid}, 32'hFF);
      check("bcast_occ", {28'd0, occupancy}, 32'd8);
      cycle(0, 0, 0, 0, 0, 8'h00);
      cycle(0, 0, 0, 0, 0, 8'hFF);
      check("drained_valid", {24'd0, out_valid}, 32'h00);
      check("retained_lane7", out_data[7*N +: N], 32'hA5A5A5A5);

      // Reset with lanes 0, 2, 7 full and a write to lane 1 offered.
      cycle(0, 1, 0, 0, 32'h00000010, 8'h00);
      cycle(0, 1, 0, 2, 32'h00000012, 8'h00);
      cycle(0, 1, 0, 7, 32'h00000017, 8'h00);
      cycle(1, 1, 0, 1, 32'h11111111, 8'h00);
      check("reset_lane1", out_data[1*N +: N], 32'h0);
      check("reset_occ", {28'd0, occupancy}, 32'd0);
      cycle(0, 0, 0, 0, 0, 8'h00);

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
               $urandom, 8'($urandom));
      end
      cycle(0, 0, 0, 0, 0, 8'hFF);
      cycle(0, 0, 0, 0, 0, 8'h00);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/demux1a8_buffered.md
Name: demux1a8_buffered

Overview:
- Inverse of the ALU result selector: a single N-bit producer stream is routed into one of eight destination lanes, chosen by a 3-bit control code.
- Each lane has a one-entry output buffer with its own valid/ready handshake, so a stalled destination does not block traffic to the other lanes.
- A broadcast mode writes the same word to all eight lanes in one transfer.
- Sits between the ALU result path and the per-unit consumers (writeback/flag units).

Parameters:
N, 32, data width of the input word and of each lane

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  producer has a word on data_in
in_ready  output  1  block accepts the word this cycle (combinational)
data_in  input  N  word to route
control  input  3  destination lane index 0..7; ignored when bcast=1
bcast  input  1  write data_in to all eight lanes
out_valid  output  8  bit i: lane i buffer holds a word
out_ready  input  8  bit i: consumer i takes the lane i word this cycle
out_data  output  8*N  lane i word at bits [i*N +: N]
occupancy  output  4  registered count of set out_valid bits, 0..8

Behaviour:
- Reset (reset=1 at a clock edge):
  - out_valid=0, out_data=0, occupancy=0.
  - Reset mid-operation discards all pending words; no transfer completes in a reset cycle.
  - in_ready is 0 while reset=1.
- Lane drain: lane i drains when out_valid[i] && out_ready[i]. out_ready[i] with out_valid[i]=0 has no effect.
- Lane free: lane i is free this cycle when !out_valid[i] || out_ready[i].
- in_ready:
  - bcast=0: in_ready = free(lane control).
  - bcast=1: in_ready = AND of free(i) for all i.
- Accept: an input transfer occurs on in_valid && in_ready. Latency is 1 cycle: the word appears in out_data and out_valid is set at the following edge.
- Lane update at each edge, in priority order:
  1. Lane written by the accepted transfer: out_valid[i]=1, out_data lane i = data_in. This covers the simultaneous drain-and-refill case: valid stays 1 and data is replaced.
  2. Else if lane i drains: out_valid[i]=0, data unchanged.
  3. Else: hold.
- Stability: while out_valid[i]=1 and out_ready[i]=0, lane i data is stable. Unselected lanes are never modified by a transfer.
- No handshake on data_in without in_valid: in_valid=0 leaves all buffers unchanged except drains.
- occupancy equals popcount of out_valid, updated in the same edge as out_valid, so it always matches the current out_valid.
- Defined-value requirements: control and bcast are sampled only when in_valid=1. Outputs never take 'z or 'x after reset.
- No internal FSM beyond per-lane valid bits. in_ready is the only combinational path (from out_valid, out_ready, control, bcast).

Test Plan:
- Reset, then a single write:
  - Stimulus: reset 2 cycles, then in_valid=1, control=3, data_in=32'hDEADBEEF, all out_ready=0.
  - Response: in_ready=1. Next cycle out_valid=8'b0000_1000, lane 3 = DEADBEEF, occupancy=1, other lanes 0.
- Backpressure on a full lane:
  - Stimulus: with lane 3 full and out_ready[3]=0, present control=3, data_in=32'h1.
  - Response: in_ready=0, lane 3 still DEADBEEF.
  - Stimulus: same cycle, present control=5, data_in=32'h55.
  - Response: accepted; out_valid=8'b0010_1000, occupancy=2.
- Drain and refill in one cycle:
  - Stimulus: lane 3 full, out_ready[3]=1, in_valid=1, control=3, data_in=32'hCAFE0001.
  - Response: in_ready=1. Next cycle out_valid[3]=1, lane 3 = CAFE0001, occupancy unchanged.
- Broadcast blocked, then accepted:
  - Stimulus: bcast=1, data_in=32'hA5A5A5A5, lane 5 full with out_ready[5]=0.
  - Response: in_ready=0.
  - Stimulus: raise out_ready[5]=1 with all other lanes empty.
  - Response: accepted; next cycle out_valid=8'hFF, all lanes A5A5A5A5, occupancy=8.
- Drain all lanes:
  - Stimulus: from occupancy=8, out_ready=8'hFF for 1 cycle with in_valid=0.
  - Response: out_valid=0, occupancy=0, lane data retained.
- Reset mid-operation:
  - Stimulus: lanes 0, 2 and 7 full; assert reset together with in_valid=1, control=1.
  - Response: next cycle out_valid=0, out_data=0, occupancy=0, and nothing written to lane 1.
